burst_delay_line: RTL and testbench
===================================

Name: burst_delay_line

Overview:
- Parametrised successor of the single-stage burst delay register.
- Delays a W-bit burst sample stream by a runtime-programmable number of EN-qualified samples, 0..MAX_DEPTH, using a circular buffer.
- Adds fill/valid tracking, flush, and out-of-range delay detection.
- Sits between the burst sequencer and the waveform output path so channel bursts can be time-aligned.

Parameters:
- W, 34, data width of Din/Dout.
- MAX_DEPTH, 16, maximum programmable delay in EN samples (≥1, power of two).
- DW, 5, width of Delay port; must satisfy 2^DW > MAX_DEPTH.

Ports:
- Clock  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-low reset.
- EN  in  1  sample strobe; every state update other than Load/Flush/reset is gated by EN.
- Din  in  W  input sample, captured when EN=1.
- Load  in  1  one-cycle pulse; latch Delay and flush.
- Delay  in  DW  requested delay, sampled only when Load=1.
- Flush  in  1  one-cycle pulse; restart fill without changing the delay.
- Dout  out  W  delayed sample (registered).
- Dout_Valid  out  1  Dout holds a real sample, not fill data.
- Delay_Err  out  1  sticky: last Load requested Delay > MAX_DEPTH.
- Fill  out  DW  samples held since last flush, saturating at the active delay.

Behaviour:
- All state changes on rising Clock only; fully synchronous.
- Reset=0 (highest priority):
  - Dout=0, Dout_Valid=0, Delay_Err=0, Fill=0.
  - Write pointer=0; active delay D=0.
  - Buffer contents are don't-care and are not cleared.
- Priority order: Reset > Load > Flush > EN.
- Load=1:
  - D <= min(Delay, MAX_DEPTH).
  - Delay_Err <= (Delay > MAX_DEPTH); cleared by any later in-range Load.
  - Fill <= 0, Dout_Valid <= 0, write pointer <= 0, Dout unchanged.
  - An EN in the same cycle is dropped: not written, no output update.
- Flush=1 (Load=0):
  - Same as Load except D and Delay_Err are unchanged.
  - An EN in the same cycle is dropped.
- EN=1 with no Load/Flush:
  - D=0: Dout <= Din; Dout_Valid <= 1. Identical to the legacy single-stage register.
  - D≥1:
    - Dout <= mem[(wptr − D) mod MAX_DEPTH] (read-before-write in the same cycle).
    - mem[wptr] <= Din.
    - wptr <= (wptr+1) mod MAX_DEPTH.
    - Dout_Valid <= (Fill ≥ D).
    - Fill <= min(Fill+1, D).
  - Result: output at EN sample n equals Din of EN sample n−D. Output-register latency is 1 clock after the qualifying EN edge.
- EN=0: all outputs and state hold; buffer not written.
- D=MAX_DEPTH: read and write address coincide; read returns the old word. Buffer must be read-before-write, whether registers or distributed RAM.
- Pointer wrap: modulo MAX_DEPTH, no bubble at wrap.
- Dout while Dout_Valid=0 is don't-care to consumers. The bench checks only Dout_Valid, not Dout, during fill.
- Reset asserted mid-burst: the next cycle shows reset values; the first post-reset EN behaves as D=0.

Decomposition:
- Shared package burst_pkg:
  - Default W=34 and the MAX_DEPTH default.
  - Zero-word constant used for the Dout reset value.
  - Priority encoding of the control enum {CTL_RESET, CTL_LOAD, CTL_FLUSH, CTL_SHIFT, CTL_HOLD}.
- One sub-module, burst_delay_ram:
  - MAX_DEPTH×W storage with one write port and one asynchronous read port.
  - Read-before-write semantics.
  - Keeps storage inference separate from pointer/fill control.

Test Plan:
1. Reset=0 then EN=1 with Din=34'h3_0000_0001, 34'h3_0000_0002 -> Dout tracks Din one clock later (D=0); Dout_Valid=1 after the first EN.
2. Load Delay=3, then EN every cycle with Din=1,2,3,4,5,6 -> Dout_Valid=0 for the first 3 EN; Dout=1,2,3 on EN 4,5,6; Fill saturates at 3.
3. Load Delay=16, EN with gaps (EN=1 every other cycle), Din=0..40 -> Dout=Din−16 from EN 17 on; holds across EN=0 cycles; wrap at wptr 15→0 is seamless.
4. Load Delay=20 -> Delay_Err=1, D=16. Then Load Delay=2 -> Delay_Err=0, D=2.
5. Mid-stream at D=4: Flush with EN=1 in the same cycle -> that sample is not written; Dout_Valid=0 for the next 4 EN; D remains 4.
6. Reset=0 asserted during streaming at D=8 -> Dout=0, Dout_Valid=0, Fill=0 next cycle; subsequent EN passes Din straight through (D=0).

Source files
------------

// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared defaults, reset word and control priority decode for the burst delay line
package burst_pkg;

    localparam int W_DEFAULT         = 34;
    localparam int MAX_DEPTH_DEFAULT = 16;
    localparam int DW_DEFAULT        = 5;

    localparam logic [W_DEFAULT-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        CTL_RESET,
        CTL_LOAD,
        CTL_FLUSH,
        CTL_SHIFT,
        CTL_HOLD
    } ctl_e;

    // Reset > Load > Flush > EN; Reset is active-low
    function automatic ctl_e ctl_decode(input logic resetn, input logic load,
                                        input logic flush, input logic en);
        if (!resetn)    return CTL_RESET;
        else if (load)  return CTL_LOAD;
        else if (flush) return CTL_FLUSH;
        else if (en)    return CTL_SHIFT;
        else            return CTL_HOLD;
    endfunction

endpackage

// File: rtl/burst_delay_line_if.sv
// rtl/burst_delay_line_if.sv - sample stream, delay control and status bundle
interface burst_delay_line_if #(
    parameter int W  = burst_pkg::W_DEFAULT,
    parameter int DW = burst_pkg::DW_DEFAULT
);
    logic          EN;
    logic [W-1:0]  Din;
    logic          Load;
    logic [DW-1:0] Delay;
    logic          Flush;
    logic [W-1:0]  Dout;
    logic          Dout_Valid;
    logic          Delay_Err;
    logic [DW-1:0] Fill;

    modport master (
        output EN, Din, Load, Delay, Flush,
        input  Dout, Dout_Valid, Delay_Err, Fill
    );

    modport slave (
        input  EN, Din, Load, Delay, Flush,
        output Dout, Dout_Valid, Delay_Err, Fill
    );
endinterface

// File: rtl/burst_delay_ram.sv
// rtl/burst_delay_ram.sv - circular sample store, one write port and one asynchronous read port
module burst_delay_ram #(
    parameter int W     = 34,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          Clock,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [W-1:0]  wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [W-1:0]  rdata_o
);
    logic [W-1:0] mem_q [DEPTH];

    // Contents are never reset; the async read sees the pre-edge word, giving read-before-write
    always_ff @(posedge Clock) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/burst_delay_line.sv
// rtl/burst_delay_line.sv - runtime-programmable EN-sample delay with fill tracking, flush and range check
module burst_delay_line
    import burst_pkg::*;
#(
    parameter int W         = W_DEFAULT,
    parameter int MAX_DEPTH = MAX_DEPTH_DEFAULT,
    parameter int DW        = DW_DEFAULT
) (
    input  logic                Clock,
    input  logic                Reset,
    burst_delay_line_if.slave   bus
);
    localparam int            AW        = (MAX_DEPTH > 1) ? $clog2(MAX_DEPTH) : 1;
    localparam logic [DW-1:0] MAX_D     = DW'(MAX_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(MAX_DEPTH - 1);

    ctl_e          ctl;
    logic [W-1:0]  dout_q, dout_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;
    logic [DW-1:0] fill_q, fill_d;
    logic [DW-1:0] delay_q, delay_d;
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] raddr;
    logic [W-1:0]  rdata;
    logic          we;

    assign ctl   = ctl_decode(Reset, bus.Load, bus.Flush, bus.EN);
    // delay == MAX_DEPTH truncates to zero offset: read and write hit the same word
    assign raddr = (MAX_DEPTH == 1) ? '0 : AW'(wptr_q - AW'(delay_q));

    burst_delay_ram #(
        .W     (W),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .Clock   (Clock),
        .we_i    (we),
        .waddr_i (wptr_q),
        .wdata_i (bus.Din),
        .raddr_i (raddr),
        .rdata_o (rdata)
    );

    always_ff @(posedge Clock) begin
        dout_q  <= dout_d;
        valid_q <= valid_d;
        err_q   <= err_d;
        fill_q  <= fill_d;
        delay_q <= delay_d;
        wptr_q  <= wptr_d;
    end

    always_comb begin
        dout_d  = dout_q;
        valid_d = valid_q;
        err_d   = err_q;
        fill_d  = fill_q;
        delay_d = delay_q;
        wptr_d  = wptr_q;
        we      = 1'b0;
        case (ctl)
            CTL_RESET: begin
                dout_d  = W'(ZERO_WORD);
                valid_d = 1'b0;
                err_d   = 1'b0;
                fill_d  = '0;
                delay_d = '0;
                wptr_d  = '0;
            end
            CTL_LOAD: begin
                delay_d = (bus.Delay > MAX_D) ? MAX_D : bus.Delay;
                err_d   = (bus.Delay > MAX_D);
                fill_d  = '0;
                valid_d = 1'b0;
                wptr_d  = '0;
            end
            CTL_FLUSH: begin
                fill_d  = '0;
                valid_d = 1'b0;
                wptr_d  = '0;
            end
            CTL_SHIFT: begin
                if (delay_q == '0) begin
                    dout_d  = bus.Din;
                    valid_d = 1'b1;
                end else begin
                    dout_d  = rdata;
                    we      = 1'b1;
                    wptr_d  = (wptr_q == LAST_ADDR) ? '0 : wptr_q + AW'(1);
                    valid_d = (fill_q >= delay_q);
                    fill_d  = (fill_q < delay_q) ? fill_q + DW'(1) : delay_q;
                end
            end
            default: ;
        endcase
    end

    assign bus.Dout       = dout_q;
    assign bus.Dout_Valid = valid_q;
    assign bus.Delay_Err  = err_q;
    assign bus.Fill       = fill_q;
endmodule

// File: tb/tb_burst_delay_line.sv
// tb/tb_burst_delay_line.sv - directed and random stimulus against a history-queue reference model
module tb_burst_delay_line;
    localparam int W         = 34;
    localparam int MAX_DEPTH = 16;
    localparam int DW        = 5;

    logic Clock = 1'b0;
    logic Reset;
    always #5 Clock = ~Clock;

    burst_delay_line_if #(.W(W), .DW(DW)) bus ();

    burst_delay_line #(
        .W         (W),
        .MAX_DEPTH (MAX_DEPTH),
        .DW        (DW)
    ) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference: samples written since the last flush, trimmed to the active delay
    int           m_d;
    bit           m_err;
    bit           m_valid;
    bit           m_dout_known;
    logic [W-1:0] m_dout;
    logic [W-1:0] hist[$];

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic cycle(input logic rst, input logic en, input logic [W-1:0] din,
                         input logic ld, input logic [DW-1:0] dly, input logic fl);
        Reset     = rst;
        bus.EN    = en;
        bus.Din   = din;
        bus.Load  = ld;
        bus.Delay = dly;
        bus.Flush = fl;
        @(posedge Clock);
        cyc++;
        if (!rst) begin
            m_d = 0; m_err = 0; m_valid = 0; m_dout = '0; m_dout_known = 1;
            hist.delete();
        end else if (ld) begin
            m_d   = (int'(dly) > MAX_DEPTH) ? MAX_DEPTH : int'(dly);
            m_err = (int'(dly) > MAX_DEPTH);
            m_valid = 0;
            hist.delete();
        end else if (fl) begin
            m_valid = 0;
            hist.delete();
        end else if (en) begin
            if (m_d == 0) begin
                m_dout = din; m_valid = 1; m_dout_known = 1;
            end else begin
                m_valid = (hist.size() >= m_d);
                if (m_valid) m_dout = hist[hist.size() - m_d];
                m_dout_known = m_valid;
                hist.push_back(din);
                if (hist.size() > m_d) void'(hist.pop_front());
            end
        end
        #1;
        check_val("valid", 64'(bus.Dout_Valid), 64'(m_valid));
        check_val("err",   64'(bus.Delay_Err),  64'(m_err));
        check_val("fill",  64'(bus.Fill),       64'(hist.size()));
        if (m_dout_known) check_val("dout", 64'(bus.Dout), 64'(m_dout));
    endtask

    task automatic shift(input logic [W-1:0] din);
        cycle(1'b1, 1'b1, din, 1'b0, '0, 1'b0);
    endtask

    task automatic idle();
        cycle(1'b1, 1'b0, '0, 1'b0, '0, 1'b0);
    endtask

    task automatic load(input logic [DW-1:0] dly);
        cycle(1'b1, 1'b0, '0, 1'b1, dly, 1'b0);
    endtask

    initial begin
        // 1: reset then pass-through at D=0
        cycle(1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cycle(1'b0, 1'b1, 34'h1_2345_6789, 1'b0, '0, 1'b0);
        shift(34'h3_0000_0001);
        shift(34'h3_0000_0002);

        // 2: delay 3, back-to-back EN
        load(5'd3);
        for (int i = 1; i <= 6; i++) shift(W'(i));
        check_val("tp2_dout", 64'(bus.Dout), 64'd3);
        check_val("tp2_fill", 64'(bus.Fill), 64'd3);

        // 3: delay 16 with EN every other cycle, across pointer wrap
        load(5'd16);
        for (int i = 0; i <= 40; i++) begin
            shift(W'(i));
            idle();
        end
        check_val("tp3_dout", 64'(bus.Dout), 64'd24);

        // 4: out-of-range delay clamps, in-range load clears the error
        load(5'd20);
        check_val("tp4_err", 64'(bus.Delay_Err), 64'd1);
        for (int i = 0; i < 18; i++) shift(W'(100 + i));
        check_val("tp4_clamp", 64'(bus.Dout), 64'd101);
        load(5'd2);
        check_val("tp4_clr", 64'(bus.Delay_Err), 64'd0);
        for (int i = 0; i < 4; i++) shift(W'(200 + i));

        // 5: flush with a simultaneous EN at D=4
        load(5'd4);
        for (int i = 0; i < 6; i++) shift(W'(300 + i));
        cycle(1'b1, 1'b1, W'(999), 1'b0, '0, 1'b1);
        for (int i = 0; i < 6; i++) shift(W'(400 + i));
        check_val("tp5_dout", 64'(bus.Dout), 64'd401);

        // 6: reset during streaming at D=8
        load(5'd8);
        for (int i = 0; i < 12; i++) shift(W'(500 + i));
        cycle(1'b0, 1'b1, W'(777), 1'b0, '0, 1'b0);
        check_val("tp6_dout0", 64'(bus.Dout), 64'd0);
        shift(34'h2_AAAA_5555);
        check_val("tp6_pass", 64'(bus.Dout), 64'h2_AAAA_5555);

        // Random mix of loads, flushes, resets and gapped EN
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [W-1:0] d;
            r = int'($urandom_range(0, 999));
            d = {W'($urandom()), 2'($urandom())};
            if (r < 5)        cycle(1'b0, 1'($urandom()), d, 1'b0, '0, 1'b0);
            else if (r < 25)  cycle(1'b1, 1'($urandom()), d, 1'b1, 5'($urandom_range(0, 31)), 1'($urandom()));
            else if (r < 45)  cycle(1'b1, 1'($urandom()), d, 1'b0, 5'($urandom()), 1'b1);
            else if (r < 650) cycle(1'b1, 1'b1, d, 1'b0, 5'($urandom()), 1'b0);
            else              cycle(1'b1, 1'b0, d, 1'b0, 5'($urandom()), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
